instr_mem: RTL and testbench
============================

# instr_mem

Parametrised instruction memory for the fetch stage, replacing the fixed 64×16 combinational ROM. Contents are written at run time by a byte-serial loader. Fetches use a registered read with a one-cycle latency, a valid/ready handshake and stall hold. It sits between the boot/UART loader and the core's fetch/decode boundary.

## Interface
- DATA_W, 16: instruction width in bits; must be a multiple of 8 and ≥ 8.
- ADDR_W, 6: pc width; DEPTH = 2**ADDR_W words.
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  reset; asynchronous, active-high.
- load_start  in  1  one-cycle pulse; enters LOAD and clears the write pointer and byte index.
- load_valid  in  1  load_byte is valid.
- load_byte  in  8  loader data; little-endian, so the first byte of a word lands in bits [7:0].
- load_last  in  1  qualifies the final byte of the image.
- load_ready  out  1  high in LOAD only.
- load_done  out  1  sticky; set when a load completes.
- load_err  out  1  sticky; set on overflow; cleared by load_start.
- fetch_valid  in  1  fetch request.
- pc  in  ADDR_W  fetch address.
- fetch_ready  out  1  equals (state==RUN) && !stall.
- stall  in  1  downstream hold.
- instr  out  DATA_W  fetched word.
- instr_valid  out  1  instr holds a fresh fetch result.

## Operation
- FSM has two states: RUN (reset state) and LOAD.
- Memory array has no reset. Contents are undefined until the first load.
- RUN → LOAD on load_start. load_start in LOAD restarts the load:
  - wptr=0, bidx=0, partial word cleared, load_err=0.
  - load_done=0 whenever LOAD is entered.
- A byte is accepted when load_valid && load_ready. Priority: a load_start in the same cycle wins and the byte is dropped.
- Accepted byte goes into byte lane bidx of the assembly register.
- A word is written to mem[wptr] on the accepting edge when either:
  - bidx == DATA_W/8-1, or
  - load_last=1; missing upper bytes are written as zero.
- After each write, wptr increments and bidx returns to 0.
- Overflow: any byte accepted after DEPTH words have been written is consumed and discarded, and load_err is set.
  - wptr saturates at DEPTH; it never wraps onto word 0.
- load_last accepted → FSM goes to RUN and load_done=1 on the same edge.
- Fetch: on an edge with fetch_valid && fetch_ready, instr ← mem[pc] and instr_valid ← 1.
- Not stall and no fetch accepted → instr_valid ← 0; instr holds its last value.
- stall=1 → instr and instr_valid hold. No new fetch is accepted (fetch_ready=0).
- LOAD state: fetch_ready=0, and instr_valid ← 0 on the first LOAD edge unless stall holds it.

## Timing
- Reset values:
  - state=RUN; instr=0, instr_valid=0;
  - load_ready=0, load_done=0, load_err=0;
  - fetch_ready=1 (when stall=0).
- Reset asserted mid-load aborts immediately. Partially written memory keeps its contents; the assembly register is cleared.
- Fetch latency is 1 cycle: request at edge N, and instr/instr_valid are valid after edge N.
- Back-to-back fetches sustain 1 per cycle.
- Load throughput is 1 byte per cycle. A word is visible to fetch on the cycle after its write edge.
- Fetching is possible in the first RUN cycle after load_last; that cycle reads the final word correctly.
- Read and write never occur in the same cycle, so no bypass is needed.

## Test plan
- DATA_W=16, ADDR_W=6.
  - Stimulus: load bytes 34 12 78 56 with last on 56, then fetch pc=0 and pc=1.
  - Required: instr=0x1234, then 0x5678, each 1 cycle after its request; load_done=1; load_err=0.
- Odd-byte terminator.
  - Stimulus: load AB CD EF with last on EF, then fetch pc=1.
  - Required: instr=0x00EF; load_done=1.
- Overflow.
  - Stimulus: stream 130 bytes without last, then 1 byte with last.
  - Required: load_err=1; mem[0] is unchanged from the first word; load_done=1; fetch_ready returns to 1.
- Stall during fetch.
  - Stimulus: fetch pc=3, then stall=1 for 3 cycles while fetch_valid=1 with pc=4.
  - Required: instr=mem[3] and instr_valid=1 held; fetch_ready=0; mem[4] appears 1 cycle after stall drops.
- Mid-load interruptions.
  - Stimulus: load_start mid-load, and separately rst asserted mid-load.
  - Required for load_start: wptr restarts at 0, load_done=0, load_err cleared.
  - Required for rst: outputs at reset values asynchronously; state=RUN.
- Priority.
  - Stimulus: load_start coincident with load_valid in LOAD.
  - Required: byte dropped; the next byte lands in mem[0][7:0].

Source files
------------

// File: rtl/instr_mem.sv
// Instruction memory for fetch, filled at run time by a byte-serial loader.
// Fetch latency: 1 cycle (registered read); load throughput 1 byte per cycle.
// Backpressure: stall holds instr/instr_valid and blocks fetches; load_ready is high only in LOAD.
module instr_mem #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_start,
  input  logic              load_valid,
  input  logic [7:0]        load_byte,
  input  logic              load_last,
  output logic              load_ready,
  output logic              load_done,
  output logic              load_err,
  input  logic              fetch_valid,
  input  logic [ADDR_W-1:0] pc,
  output logic              fetch_ready,
  input  logic              stall,
  output logic [DATA_W-1:0] instr,
  output logic              instr_valid
);

  localparam int NBYTES = DATA_W / 8;
  localparam int DEPTH  = 2 ** ADDR_W;
  localparam int BIDX_W = (NBYTES > 1) ? $clog2(NBYTES) : 1;

  typedef enum logic {RUN = 1'b0, LOAD = 1'b1} state_t;

  state_t              state;
  logic [DATA_W-1:0]   mem [DEPTH];
  // One extra bit so the pointer can rest at DEPTH instead of wrapping to word 0.
  logic [ADDR_W:0]     wptr;
  logic [BIDX_W-1:0]   bidx;
  logic [DATA_W-1:0]   asm_q;
  logic [DATA_W-1:0]   asm_next;
  logic                accept;
  logic                full;
  logic                last_lane;
  logic                word_wr;

  assign load_ready  = (state == LOAD);
  assign fetch_ready = (state == RUN) && !stall;
  // A coincident load_start wins, so the byte on that cycle is dropped.
  assign accept      = load_valid && load_ready && !load_start;
  assign full        = (wptr == (ADDR_W+1)'(DEPTH));
  assign last_lane   = (bidx == BIDX_W'(NBYTES - 1));
  assign word_wr     = accept && !full && (last_lane || load_last);

  // Merge the incoming byte into its lane; lanes above bidx are still zero,
  // so a short final word is zero-padded for free.
  always_comb begin
    asm_next = asm_q;
    for (int i = 0; i < NBYTES; i++) begin
      if (bidx == BIDX_W'(i)) asm_next[8*i +: 8] = load_byte;
    end
  end

  // Loader FSM: pointer, byte index, assembly register and sticky status.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= RUN;
      wptr      <= '0;
      bidx      <= '0;
      asm_q     <= '0;
      load_done <= 1'b0;
      load_err  <= 1'b0;
    end else if (load_start) begin
      state     <= LOAD;
      wptr      <= '0;
      bidx      <= '0;
      asm_q     <= '0;
      load_done <= 1'b0;
      load_err  <= 1'b0;
    end else if (accept) begin
      if (full) begin
        load_err <= 1'b1;
      end else if (last_lane || load_last) begin
        wptr  <= wptr + (ADDR_W+1)'(1);
        bidx  <= '0;
        asm_q <= '0;
      end else begin
        bidx  <= bidx + BIDX_W'(1);
        asm_q <= asm_next;
      end
      if (load_last) begin
        state     <= RUN;
        load_done <= 1'b1;
      end
    end
  end

  // Memory array write port; contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (word_wr) mem[wptr[ADDR_W-1:0]] <= asm_next;
  end

  // Registered fetch with stall hold; valid drops when nothing is fetched.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      instr       <= '0;
      instr_valid <= 1'b0;
    end else if (fetch_valid && fetch_ready) begin
      instr       <= mem[pc];
      instr_valid <= 1'b1;
    end else if (!stall) begin
      instr_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_instr_mem.sv
// Self-checking bench for instr_mem: directed scenarios plus randomized loads/fetches
// compared against a word-level reference image built from the loaded byte stream.
module tb_instr_mem;
  localparam int DATA_W = 16;
  localparam int ADDR_W = 6;
  localparam int DEPTH  = 64;

  logic              clk = 1'b0;
  logic              rst;
  logic              load_start, load_valid, load_last;
  logic [7:0]        load_byte;
  logic              load_ready, load_done, load_err;
  logic              fetch_valid;
  logic [ADDR_W-1:0] pc;
  logic              fetch_ready, stall;
  logic [DATA_W-1:0] instr;
  logic              instr_valid;

  instr_mem #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst),
    .load_start(load_start), .load_valid(load_valid), .load_byte(load_byte),
    .load_last(load_last), .load_ready(load_ready), .load_done(load_done),
    .load_err(load_err), .fetch_valid(fetch_valid), .pc(pc),
    .fetch_ready(fetch_ready), .stall(stall), .instr(instr), .instr_valid(instr_valid)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  logic [15:0] ref_mem [DEPTH];
  logic [7:0]  bq [$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference image: byte k of the stream is byte (k%2) of word k/2; only whole
  // words are stored unless the stream was terminated, words past DEPTH are lost.
  task automatic ref_load(input bit with_last);
    int n;
    n = bq.size();
    for (int w = 0; w < n / 2 && w < DEPTH; w++) ref_mem[w] = {bq[2*w+1], bq[2*w]};
    if (with_last && (n % 2 == 1) && (n / 2 < DEPTH)) ref_mem[n/2] = {8'h00, bq[n-1]};
  endtask

  task automatic stream(input bit with_last);
    for (int i = 0; i < bq.size(); i++) begin
      load_valid = 1'b1;
      load_byte  = bq[i];
      load_last  = with_last && (i == bq.size() - 1);
      step();
    end
    load_valid = 1'b0;
    load_last  = 1'b0;
  endtask

  task automatic start_load();
    load_start = 1'b1;
    step();
    load_start = 1'b0;
    check("ld_ready", load_ready, 1);
    check("ld_done_clr", load_done, 0);
    check("ld_err_clr", load_err, 0);
  endtask

  task automatic full_load(input string tag);
    start_load();
    stream(1'b1);
    ref_load(1'b1);
    check({tag, "_done"}, load_done, 1);
    check({tag, "_err"}, load_err, (bq.size() > 2 * DEPTH) ? 1 : 0);
    check({tag, "_frdy"}, fetch_ready, 1);
    check({tag, "_lrdy"}, load_ready, 0);
  endtask

  task automatic fetch1(input logic [ADDR_W-1:0] a, input string tag);
    fetch_valid = 1'b1;
    pc          = a;
    step();
    fetch_valid = 1'b0;
    check({tag, "_iv"}, instr_valid, 1);
    check({tag, "_instr"}, instr, ref_mem[a]);
  endtask

  task automatic rand_bytes(input int n);
    bq.delete();
    for (int i = 0; i < n; i++) bq.push_back(8'($urandom));
  endtask

  logic [15:0] exp_instr;
  logic        exp_valid;
  logic [15:0] hold_instr;

  initial begin
    rst = 1'b1; load_start = 0; load_valid = 0; load_last = 0; load_byte = 0;
    fetch_valid = 0; pc = 0; stall = 0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_instr", instr, 0);
    check("rst_iv", instr_valid, 0);
    check("rst_lrdy", load_ready, 0);
    check("rst_done", load_done, 0);
    check("rst_err", load_err, 0);
    check("rst_frdy", fetch_ready, 1);
    rst = 1'b0;
    step();

    // Two full words, fetched back to back starting in the first RUN cycle.
    bq = '{8'h34, 8'h12, 8'h78, 8'h56};
    full_load("t1");
    fetch_valid = 1'b1; pc = 0;
    step();
    check("t1_w0", instr, 16'h1234);
    check("t1_w0_iv", instr_valid, 1);
    pc = 1;
    step();
    fetch_valid = 1'b0;
    check("t1_w1", instr, 16'h5678);
    check("t1_w1_iv", instr_valid, 1);

    // Odd-length image: last word is zero padded.
    bq = '{8'hAB, 8'hCD, 8'hEF};
    full_load("t2");
    fetch1(1, "t2_w1");
    check("t2_pad", instr, 16'h00EF);
    fetch1(0, "t2_w0");
    step();
    check("idle_iv", instr_valid, 0);
    check("idle_hold", instr, 16'hCDAB);

    // Overflow: 130 bytes then one terminating byte.
    rand_bytes(131);
    full_load("ovf");
    fetch1(0, "ovf_w0");
    check("ovf_w0_first", instr, {bq[1], bq[0]});
    fetch1(63, "ovf_w63");

    // Stall holds the previous result and blocks the pending fetch.
    fetch1(3, "st_pre");
    fetch_valid = 1'b1; pc = 4; stall = 1'b1;
    #1;
    check("st_frdy", fetch_ready, 0);
    for (int i = 0; i < 3; i++) begin
      step();
      check("st_hold", instr, ref_mem[3]);
      check("st_hold_iv", instr_valid, 1);
    end
    stall = 1'b0;
    step();
    fetch_valid = 1'b0;
    check("st_rel", instr, ref_mem[4]);
    check("st_rel_iv", instr_valid, 1);

    // Restart mid-load after an overflow, with a coincident byte that must be dropped.
    start_load();
    rand_bytes(131);
    stream(1'b0);
    ref_load(1'b0);
    check("rs_err_set", load_err, 1);
    check("rs_busy_done", load_done, 0);
    load_start = 1'b1; load_valid = 1'b1; load_byte = 8'hEE;
    step();
    load_start = 1'b0; load_valid = 1'b0;
    check("rs_err_clr", load_err, 0);
    check("rs_done_clr", load_done, 0);
    check("rs_lrdy", load_ready, 1);
    bq = '{8'h11, 8'h22};
    stream(1'b1);
    ref_load(1'b1);
    check("rs_done", load_done, 1);
    fetch1(0, "rs_w0");
    check("rs_w0_lit", instr, 16'h2211);

    // Asynchronous reset in the middle of a load.
    start_load();
    rand_bytes(3);
    stream(1'b0);
    ref_load(1'b0);
    #2 rst = 1'b1;
    #1;
    check("ar_lrdy", load_ready, 0);
    check("ar_done", load_done, 0);
    check("ar_err", load_err, 0);
    check("ar_iv", instr_valid, 0);
    check("ar_instr", instr, 0);
    check("ar_frdy", fetch_ready, 1);
    #1 rst = 1'b0;
    step();
    fetch1(0, "ar_w0");

    // Randomized loads followed by random fetch/stall/idle traffic.
    for (int r = 0; r < 6; r++) begin
      rand_bytes($urandom_range(1, 140));
      full_load("rnd_ld");
      exp_instr = instr;
      exp_valid = instr_valid;
      for (int c = 0; c < 30; c++) begin
        fetch_valid = 1'($urandom);
        stall       = ($urandom_range(0, 3) == 0);
        pc          = ADDR_W'($urandom);
        #1;
        check("rnd_frdy", fetch_ready, !stall);
        hold_instr = ref_mem[pc];
        if (!stall && fetch_valid) begin
          exp_instr = hold_instr;
          exp_valid = 1'b1;
        end else if (!stall) begin
          exp_valid = 1'b0;
        end
        step();
        check("rnd_iv", instr_valid, exp_valid);
        check("rnd_instr", instr, exp_instr);
      end
      fetch_valid = 1'b0;
      stall       = 1'b0;
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
